// File: rtl/adder_operand_sequencer.sv
// Captures two operands from switches, waits for the external adder to settle, then latches its sum.
// Define ADDER_SEQ_ACCUM_EN to make a load in DONE feed the result back as operand A (running sum).
module adder_operand_sequencer #(
  parameter int OP_WIDTH      = 3,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [OP_WIDTH-1:0] switches,
  input  logic                load_pulse,
  input  logic                clear_pulse,
  output logic [OP_WIDTH-1:0] op_a,
  output logic [OP_WIDTH-1:0] op_b,
  input  logic [OP_WIDTH:0]   sum_in,
  output logic [OP_WIDTH:0]   result,
  output logic                result_valid,
  output logic [1:0]          state
);

  typedef enum logic [1:0] {
    WAIT_A = 2'b00,
    WAIT_B = 2'b01,
    SETTLE = 2'b10,
    DONE   = 2'b11
  } state_t;

  state_t              r_state;
  state_t              w_nextState;
  logic [OP_WIDTH-1:0] r_opA;
  logic [OP_WIDTH-1:0] w_nextOpA;
  logic [OP_WIDTH-1:0] r_opB;
  logic [OP_WIDTH-1:0] w_nextOpB;
  logic [OP_WIDTH:0]   r_result;
  logic [OP_WIDTH:0]   w_nextResult;
  logic                r_valid;
  logic                w_nextValid;
  logic [3:0]          r_settleCnt;
  logic [3:0]          w_nextSettleCnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= WAIT_A;
      r_opA       <= '0;
      r_opB       <= '0;
      r_result    <= '0;
      r_valid     <= 1'b0;
      r_settleCnt <= '0;
    end else begin
      r_state     <= w_nextState;
      r_opA       <= w_nextOpA;
      r_opB       <= w_nextOpB;
      r_result    <= w_nextResult;
      r_valid     <= w_nextValid;
      r_settleCnt <= w_nextSettleCnt;
    end
  end

  // Clear overrides everything, including a simultaneous load.
  always_comb begin
    w_nextState     = r_state;
    w_nextOpA       = r_opA;
    w_nextOpB       = r_opB;
    w_nextResult    = r_result;
    w_nextValid     = r_valid;
    w_nextSettleCnt = r_settleCnt;
    if (clear_pulse) begin
      w_nextState     = WAIT_A;
      w_nextOpA       = '0;
      w_nextOpB       = '0;
      w_nextResult    = '0;
      w_nextValid     = 1'b0;
      w_nextSettleCnt = '0;
    end else begin
      case (r_state)
        WAIT_A: begin
          if (load_pulse) begin
            w_nextOpA   = switches;
            w_nextState = WAIT_B;
          end
        end
        WAIT_B: begin
          if (load_pulse) begin
            w_nextOpB       = switches;
            w_nextSettleCnt = '0;
            w_nextState     = SETTLE;
          end
        end
        SETTLE: begin
          if (r_settleCnt == 4'(SETTLE_CYCLES)) begin
            w_nextResult = sum_in;
            w_nextValid  = 1'b1;
            w_nextState  = DONE;
          end else begin
            w_nextSettleCnt = r_settleCnt + 4'd1;
          end
        end
        DONE: begin
          if (load_pulse) begin
`ifdef ADDER_SEQ_ACCUM_EN
            // Carry-out is dropped: op_a only holds OP_WIDTH bits.
            w_nextOpA       = r_result[OP_WIDTH-1:0];
            w_nextOpB       = switches;
            w_nextValid     = 1'b0;
            w_nextSettleCnt = '0;
            w_nextState     = SETTLE;
`else
            w_nextOpA   = switches;
            w_nextOpB   = '0;
            w_nextValid = 1'b0;
            w_nextState = WAIT_B;
`endif
          end
        end
        default: w_nextState = WAIT_A;
      endcase
    end
  end

  assign op_a         = r_opA;
  assign op_b         = r_opB;
  assign result       = r_result;
  assign result_valid = r_valid;
  assign state        = r_state;

endmodule

// File: tb/tb_adder_operand_sequencer.sv
// Directed self-checking bench for adder_operand_sequencer with an ideal combinational adder.
// Compile with ADDER_SEQ_ACCUM_EN to exercise the accumulate scenario instead of the plain reload.
module tb_adder_operand_sequencer;

  localparam int OP_WIDTH      = 3;
  localparam int SETTLE_CYCLES = 2;

  logic                clk;
  logic                rst;
  logic [OP_WIDTH-1:0] switches;
  logic                loadPulse;
  logic                clearPulse;
  logic [OP_WIDTH-1:0] opA;
  logic [OP_WIDTH-1:0] opB;
  logic [OP_WIDTH:0]   sumIn;
  logic [OP_WIDTH:0]   result;
  logic                resultValid;
  logic [1:0]          state;

  int errors = 0;
  int checks = 0;

  adder_operand_sequencer #(
    .OP_WIDTH(OP_WIDTH),
    .SETTLE_CYCLES(SETTLE_CYCLES)
  ) dut (
    .clk(clk),
    .rst(rst),
    .switches(switches),
    .load_pulse(loadPulse),
    .clear_pulse(clearPulse),
    .op_a(opA),
    .op_b(opB),
    .sum_in(sumIn),
    .result(result),
    .result_valid(resultValid),
    .state(state)
  );

  // Ideal adder closing the loop around the sequencer.
  assign sumIn = {1'b0, opA} + {1'b0, opB};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Drive strobes for exactly one rising edge, then release 1 time unit later.
  task automatic applyStimulus(input logic [OP_WIDTH-1:0] sw, input logic ld, input logic clr);
    switches   = sw;
    loadPulse  = ld;
    clearPulse = clr;
    @(posedge clk);
    #1;
    loadPulse  = 1'b0;
    clearPulse = 1'b0;
  endtask

  // Counts edges until result_valid rises; 99 flags an expired bound.
  task automatic waitDone(output int edges);
    edges = 99;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk);
      #1;
      if (resultValid) begin
        edges = i;
        break;
      end
    end
  endtask

  initial begin
    int edges;
    int validSeen;
    switches   = '0;
    loadPulse  = 1'b0;
    clearPulse = 1'b0;
    rst        = 1'b1;
    #2;
    checkOutput("reset_state", {30'd0, state}, 32'd0);
    checkOutput("reset_opa", {29'd0, opA}, 32'd0);
    checkOutput("reset_result", {28'd0, result}, 32'd0);
    checkOutput("reset_valid", {31'd0, resultValid}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    $display("[TB] A=3 B=4");
    applyStimulus(3'd3, 1'b1, 1'b0);
    checkOutput("loadA_opa", {29'd0, opA}, 32'd3);
    checkOutput("loadA_state", {30'd0, state}, 32'd1);
    applyStimulus(3'd4, 1'b1, 1'b0);
    checkOutput("loadB_opb", {29'd0, opB}, 32'd4);
    checkOutput("loadB_state", {30'd0, state}, 32'd2);
    checkOutput("loadB_valid", {31'd0, resultValid}, 32'd0);
    waitDone(edges);
    checkOutput("latency_edges", edges, SETTLE_CYCLES + 1);
    checkOutput("sum_3_4", {28'd0, result}, 32'd7);
    checkOutput("done_state", {30'd0, state}, 32'd3);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("done_hold_result", {28'd0, result}, 32'd7);
    checkOutput("done_hold_valid", {31'd0, resultValid}, 32'd1);

    $display("[TB] A=7 B=7");
    applyStimulus(3'd0, 1'b0, 1'b1);
    checkOutput("clear_state", {30'd0, state}, 32'd0);
    checkOutput("clear_result", {28'd0, result}, 32'd0);
    checkOutput("clear_valid", {31'd0, resultValid}, 32'd0);
    applyStimulus(3'd7, 1'b1, 1'b0);
    applyStimulus(3'd7, 1'b1, 1'b0);
    waitDone(edges);
    checkOutput("sum_7_7", {28'd0, result}, 32'd14);
    checkOutput("sum_7_7_msb", {31'd0, result[OP_WIDTH]}, 32'd1);
    checkOutput("sum_7_7_state", {30'd0, state}, 32'd3);

    $display("[TB] clear and load together in WAIT_B");
    applyStimulus(3'd0, 1'b0, 1'b1);
    applyStimulus(3'd6, 1'b1, 1'b0);
    checkOutput("waitb_opa", {29'd0, opA}, 32'd6);
    applyStimulus(3'd3, 1'b1, 1'b1);
    checkOutput("clrld_state", {30'd0, state}, 32'd0);
    checkOutput("clrld_opa", {29'd0, opA}, 32'd0);
    checkOutput("clrld_opb", {29'd0, opB}, 32'd0);

    $display("[TB] async reset during SETTLE");
    applyStimulus(3'd5, 1'b1, 1'b0);
    applyStimulus(3'd2, 1'b1, 1'b0);
    checkOutput("pre_rst_state", {30'd0, state}, 32'd2);
    #3;
    rst = 1'b1;
    #1;
    checkOutput("async_rst_state", {30'd0, state}, 32'd0);
    checkOutput("async_rst_opa", {29'd0, opA}, 32'd0);
    checkOutput("async_rst_opb", {29'd0, opB}, 32'd0);
    checkOutput("async_rst_result", {28'd0, result}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    validSeen = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (resultValid) validSeen++;
    end
    checkOutput("post_rst_no_valid", validSeen, 32'd0);
    checkOutput("post_rst_state", {30'd0, state}, 32'd0);

`ifdef ADDER_SEQ_ACCUM_EN
    $display("[TB] accumulate A=2 B=3 then +1 +4");
    applyStimulus(3'd2, 1'b1, 1'b0);
    applyStimulus(3'd3, 1'b1, 1'b0);
    waitDone(edges);
    checkOutput("acc_sum5", {28'd0, result}, 32'd5);
    applyStimulus(3'd1, 1'b1, 1'b0);
    checkOutput("acc_state_settle", {30'd0, state}, 32'd2);
    checkOutput("acc_opa5", {29'd0, opA}, 32'd5);
    checkOutput("acc_valid_clr", {31'd0, resultValid}, 32'd0);
    waitDone(edges);
    checkOutput("acc_latency", edges, SETTLE_CYCLES + 1);
    checkOutput("acc_sum6", {28'd0, result}, 32'd6);
    applyStimulus(3'd4, 1'b1, 1'b0);
    checkOutput("acc_opa6", {29'd0, opA}, 32'd6);
    checkOutput("acc_opb4", {29'd0, opB}, 32'd4);
    waitDone(edges);
    checkOutput("acc_sum10", {28'd0, result}, 32'd10);
`else
    $display("[TB] reload from DONE with switches=5");
    applyStimulus(3'd1, 1'b1, 1'b0);
    applyStimulus(3'd2, 1'b1, 1'b0);
    waitDone(edges);
    checkOutput("pre_reload_sum", {28'd0, result}, 32'd3);
    applyStimulus(3'd5, 1'b1, 1'b0);
    checkOutput("reload_opa", {29'd0, opA}, 32'd5);
    checkOutput("reload_opb", {29'd0, opB}, 32'd0);
    checkOutput("reload_valid", {31'd0, resultValid}, 32'd0);
    checkOutput("reload_state", {30'd0, state}, 32'd1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
